prm_edge_chk_sched: RTL and testbench

PRM_EDGE_CHK_SCHED -- requirements
Module: prm_edge_chk_sched

---
 rtl/prm_edge_chk_sched.sv | 135 +++++++++++++
 tb/tb_prm_edge_chk_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_chk_sched.sv
// Scans N_EDGE edge checkers one index per cycle and collects their edge_mask bits into a bitmap.
// Latency: start -> done after N_EDGE+2 cycles (less in first-hit mode); no backpressure, start ignored unless IDLE.
module prm_edge_chk_sched #(
  parameter int N_EDGE = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              first_hit,
  input  logic              abort,
  input  logic [14:0]       code_in,
  output logic [14:0]       chk_code,
  output logic [IDX_W-1:0]  chk_idx,
  input  logic              chk_mask,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [N_EDGE-1:0] mask_out,
  output logic [IDX_W:0]    hit_cnt,
  output logic              hit_valid,
  output logic [IDX_W-1:0]  hit_idx
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SCAN,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EDGE - 1);

  state_t state;
  state_t state_nxt;
  logic   first_hit_q;
  logic   last_idx;
  logic   stop_hit;

  assign last_idx = (chk_idx == LAST_IDX);
  assign stop_hit = first_hit_q && chk_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort has priority over both normal and first-hit completion.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = abort ? IDLE : SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (stop_hit || last_idx) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_code    <= '0;
      chk_idx     <= '0;
      first_hit_q <= 1'b0;
      aborted     <= 1'b0;
      mask_out    <= '0;
      hit_cnt     <= '0;
      hit_valid   <= 1'b0;
      hit_idx     <= '0;
    end else begin
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            chk_code    <= code_in;
            first_hit_q <= first_hit;
            chk_idx     <= '0;
            mask_out    <= '0;
            hit_cnt     <= '0;
            hit_valid   <= 1'b0;
            hit_idx     <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            aborted <= 1'b1;
          end
          chk_idx <= '0;
        end
        SCAN: begin
          if (abort) begin
            aborted <= 1'b1;
          end else begin
            mask_out[chk_idx] <= chk_mask;
            if (chk_mask) begin
              hit_cnt <= hit_cnt + (IDX_W+1)'(1);
              if (!hit_valid) begin
                hit_valid <= 1'b1;
                hit_idx   <= chk_idx;
              end
            end
            // Index parks on the last scanned edge rather than wrapping.
            if (!last_idx && !stop_hit) begin
              chk_idx <= chk_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Bench for prm_edge_chk_sched: randomized and directed scans checked against a per-edge behavioural model.
module tb_prm_edge_chk_sched;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          first_hit = 1'b0;
  logic          abort = 1'b0;
  logic [14:0]   code_in = '0;
  logic [14:0]   chk_code;
  logic [IW-1:0] chk_idx;
  logic          chk_mask;
  logic          busy, done, aborted;
  logic [N-1:0]  mask_out;
  logic [IW:0]   hit_cnt;
  logic          hit_valid;
  logic [IW-1:0] hit_idx;
  logic [N-1:0]  flags = '0;

  prm_edge_chk_sched #(.N_EDGE(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .first_hit(first_hit), .abort(abort),
    .code_in(code_in), .chk_code(chk_code), .chk_idx(chk_idx), .chk_mask(chk_mask),
    .busy(busy), .done(done), .aborted(aborted), .mask_out(mask_out),
    .hit_cnt(hit_cnt), .hit_valid(hit_valid), .hit_idx(hit_idx)
  );

  // Checker array model: each edge's mask is a fixed flag.
  assign chk_mask = flags[chk_idx];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  int exp_mask, exp_cnt, exp_valid, exp_idx, exp_done, exp_abrt, exp_lat;
  int obs_done_n, obs_abrt_n, obs_lat, obs_code_bad;

  // Walk edges in order; abort_at names the edge whose scan cycle carries abort.
  task automatic model(input logic [N-1:0] f, input bit fh, input int abort_at);
    exp_mask = 0; exp_cnt = 0; exp_valid = 0; exp_idx = 0;
    exp_done = 0; exp_abrt = 0; exp_lat = -1;
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        exp_abrt = 1;
        return;
      end
      if (f[i]) begin
        exp_mask = exp_mask | (1 << i);
        if (exp_valid == 0) begin
          exp_valid = 1;
          exp_idx = i;
        end
        exp_cnt = exp_cnt + 1;
        if (fh) begin
          exp_done = 1;
          exp_lat = i + 3;
          return;
        end
      end
    end
    exp_done = 1;
    exp_lat = N + 2;
  endtask

  // Latency is counted to the clock edge that closes the cycle in which done is high.
  task automatic run_scan(input logic [N-1:0] f, input bit fh, input logic [14:0] code,
                          input int abort_at, input bit poke);
    int s, rel;
    flags = f;
    obs_done_n = 0; obs_abrt_n = 0; obs_lat = -1; obs_code_bad = 0;
    @(negedge clk);
    start = 1'b1; first_hit = fh; code_in = code;
    @(negedge clk);
    start = 1'b0; first_hit = 1'($urandom); code_in = 15'($urandom);
    s = cyc;
    for (int k = 0; k < N + 8; k++) begin
      rel = cyc - s;
      abort = (abort_at >= 0) && (rel == abort_at + 1);
      start = poke && (rel == 3);
      if (poke && rel == 3) code_in = ~code;
      if (done) begin
        obs_done_n++;
        obs_lat = rel + 1;
      end
      if (aborted) obs_abrt_n++;
      if (busy && chk_code !== code) obs_code_bad = 1;
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if ({chk_code, chk_idx, busy, done, aborted} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %h %h %b%b%b want 0", chk_code, chk_idx, busy, done, aborted);
    end
    vectors++;
    if ({mask_out, hit_cnt, hit_valid, hit_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_results got mask=%h cnt=%0d v=%b idx=%0d want 0", mask_out, hit_cnt, hit_valid, hit_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_scan;
    run_scan(16'h0208, 1'b0, 15'h1234, -1, 1'b0);
    vectors++;
    if (mask_out !== 16'h0208) begin miscompares++; $display("FAIL full_mask got %h want 0208", mask_out); end
    vectors++;
    if (hit_cnt !== 5'd2 || hit_idx !== 4'd3 || hit_valid !== 1'b1) begin
      miscompares++; $display("FAIL full_hits got cnt=%0d idx=%0d v=%b want 2 3 1", hit_cnt, hit_idx, hit_valid);
    end
    vectors++;
    if (obs_done_n != 1 || obs_lat != 18 || obs_abrt_n != 0) begin
      miscompares++; $display("FAIL full_done got n=%0d lat=%0d ab=%0d want 1 18 0", obs_done_n, obs_lat, obs_abrt_n);
    end
    vectors++;
    if (chk_code !== 15'h1234) begin miscompares++; $display("FAIL full_code got %h want 1234", chk_code); end
  endtask

  task automatic test_first_hit;
    run_scan(16'h0208, 1'b1, 15'h0555, -1, 1'b0);
    vectors++;
    if (mask_out !== 16'h0008 || hit_cnt !== 5'd1 || hit_idx !== 4'd3) begin
      miscompares++; $display("FAIL first_hit_res got mask=%h cnt=%0d idx=%0d want 0008 1 3", mask_out, hit_cnt, hit_idx);
    end
    vectors++;
    if (obs_done_n != 1 || obs_lat != 6) begin
      miscompares++; $display("FAIL first_hit_done got n=%0d lat=%0d want 1 6", obs_done_n, obs_lat);
    end
  endtask

  task automatic test_no_hits;
    run_scan(16'h0000, 1'b0, 15'h7fff, -1, 1'b0);
    vectors++;
    if ({mask_out, hit_cnt, hit_valid, hit_idx} !== '0) begin
      miscompares++; $display("FAIL no_hits_res got mask=%h cnt=%0d v=%b idx=%0d want 0", mask_out, hit_cnt, hit_valid, hit_idx);
    end
    vectors++;
    if (obs_done_n != 1 || obs_abrt_n != 0) begin
      miscompares++; $display("FAIL no_hits_done got n=%0d ab=%0d want 1 0", obs_done_n, obs_abrt_n);
    end
  endtask

  task automatic test_abort;
    run_scan(16'h0104, 1'b0, 15'h00aa, 5, 1'b0);
    vectors++;
    if (obs_abrt_n != 1 || obs_done_n != 0) begin
      miscompares++; $display("FAIL abort_pulse got ab=%0d done=%0d want 1 0", obs_abrt_n, obs_done_n);
    end
    vectors++;
    if (mask_out !== 16'h0004 || hit_cnt !== 5'd1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_res got mask=%h cnt=%0d busy=%b want 0004 1 0", mask_out, hit_cnt, busy);
    end
  endtask

  task automatic test_busy_start_last_abort;
    run_scan(16'h8001, 1'b0, 15'h2c3d, 15, 1'b1);
    vectors++;
    if (obs_code_bad != 0 || chk_code !== 15'h2c3d) begin
      miscompares++; $display("FAIL busy_start_code got %h bad=%0d want 2c3d", chk_code, obs_code_bad);
    end
    vectors++;
    if (obs_abrt_n != 1 || obs_done_n != 0) begin
      miscompares++; $display("FAIL last_abort_pulse got ab=%0d done=%0d want 1 0", obs_abrt_n, obs_done_n);
    end
    vectors++;
    if (mask_out !== 16'h0001 || hit_cnt !== 5'd1) begin
      miscompares++; $display("FAIL last_abort_res got mask=%h cnt=%0d want 0001 1", mask_out, hit_cnt);
    end
  endtask

  task automatic test_idle_abort;
    logic [N-1:0] held;
    int ab_n;
    held = mask_out;
    ab_n = 0;
    abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (aborted || busy) ab_n++;
    end
    abort = 1'b0;
    @(negedge clk);
    if (aborted) ab_n++;
    vectors++;
    if (ab_n != 0 || mask_out !== held) begin
      miscompares++; $display("FAIL idle_abort got pulses=%0d mask=%h want 0 %h", ab_n, mask_out, held);
    end
  endtask

  task automatic test_async_reset;
    int pulses;
    flags = 16'h00ff;
    @(negedge clk);
    start = 1'b1; code_in = 15'h1111; first_hit = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({chk_code, chk_idx, busy, done, aborted, mask_out, hit_cnt, hit_valid, hit_idx} !== '0) begin
      miscompares++; $display("FAIL async_rst got code=%h idx=%0d busy=%b mask=%h cnt=%0d want 0", chk_code, chk_idx, busy, mask_out, hit_cnt);
    end
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || aborted) pulses++;
    end
    rst = 1'b0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      if (done || aborted) pulses++;
    end
    vectors++;
    if (pulses != 0) begin miscompares++; $display("FAIL rst_no_pulse got %0d want 0", pulses); end
    run_scan(16'h4810, 1'b0, 15'h0f0f, -1, 1'b0);
    vectors++;
    if (mask_out !== 16'h4810 || obs_done_n != 1 || obs_lat != 18) begin
      miscompares++; $display("FAIL post_rst_scan got mask=%h n=%0d lat=%0d want 4810 1 18", mask_out, obs_done_n, obs_lat);
    end
  endtask

  task automatic test_random;
    logic [N-1:0] f;
    bit fh;
    int ab;
    logic [14:0] code;
    for (int t = 0; t < 24; t++) begin
      f = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 4) == 0) f = '0;
      fh = 1'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N + 2)) : -1;
      code = 15'($urandom);
      model(f, fh, ab);
      run_scan(f, fh, code, ab, 1'b0);
      vectors++;
      if (int'(mask_out) !== exp_mask || int'(hit_cnt) !== exp_cnt) begin
        miscompares++; $display("FAIL rand_mask[%0d] got %h/%0d want %h/%0d", t, mask_out, hit_cnt, exp_mask, exp_cnt);
      end
      vectors++;
      if (int'(hit_valid) !== exp_valid || int'(hit_idx) !== exp_idx) begin
        miscompares++; $display("FAIL rand_hit[%0d] got v=%b idx=%0d want %0d %0d", t, hit_valid, hit_idx, exp_valid, exp_idx);
      end
      vectors++;
      if (obs_done_n != exp_done || obs_abrt_n != exp_abrt || obs_lat != exp_lat) begin
        miscompares++; $display("FAIL rand_ctrl[%0d] got d=%0d a=%0d lat=%0d want %0d %0d %0d", t, obs_done_n, obs_abrt_n, obs_lat, exp_done, exp_abrt, exp_lat);
      end
      vectors++;
      if (chk_code !== code || obs_code_bad != 0) begin
        miscompares++; $display("FAIL rand_code[%0d] got %h want %h", t, chk_code, code);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_first_hit();
    test_no_hits();
    test_abort();
    test_idle_abort();
    test_busy_start_last_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
